// File: rtl/mips_mem_pkg.sv
// Shared types and lane helpers for the MIPS data-memory responder.
// Little-endian: lane k is word[8k+7:8k].
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_RESP,
    STORE_MERGE
  } dmem_state_t;

  // Replace one byte lane of a word
  function automatic logic [31:0] merge_byte(
    input logic [31:0] word,
    input logic [1:0]  lane,
    input logic [7:0]  b
  );
    logic [31:0] w;
    w = word;
    w[8*lane +: 8] = b;
    return w;
  endfunction

  // Pull one byte lane out of a word, sign- or zero-extended
  function automatic logic [31:0] extract_byte(
    input logic [31:0] word,
    input logic [1:0]  lane,
    input logic        sext
  );
    logic [7:0] b;
    b = word[8*lane +: 8];
    return sext ? {{24{b[7]}}, b} : {24'b0, b};
  endfunction

endpackage

// File: rtl/sync_ram_1rw.sv
// Single-port word RAM, registered read.
// Read returns the old contents on a same-address write.
module sync_ram_1rw #(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Write port plus registered read-before-write
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_byte_rmw.sv
// Data-memory responder: word/byte loads and stores,
// byte stores via read-modify-write on a 1RW RAM.
module dmem_byte_rmw
  import mips_mem_pkg::*;
#(
  parameter int DEPTH    = 64,
  parameter bit SIGN_EXT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        memwrite,
  input  logic        byte_enable,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        resp_valid,
  output logic        stall,
  output logic        misaligned
);

  localparam int AW = $clog2(DEPTH);

  dmem_state_t   state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    lane_q, lane_d;
  logic          be_q, be_d;
  logic [7:0]    byte_q, byte_d;

  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  logic          unused_a;
  assign unused_a = ^a[31:AW+2];

  sync_ram_1rw #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // State and latched request fields
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      lane_q  <= '0;
      be_q    <= 1'b0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      be_q    <= be_d;
      byte_q  <= byte_d;
    end
  end

  // Next state, RAM control, stall and response decode
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    lane_d     = lane_q;
    be_d       = be_q;
    byte_d     = byte_q;
    ram_we     = 1'b0;
    ram_addr   = a[AW+1:2];
    ram_wdata  = wd;
    stall      = 1'b0;
    resp_valid = 1'b0;
    rd         = '0;
    misaligned = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          misaligned = !byte_enable && (a[1:0] != 2'b00);
          if (memwrite && !byte_enable) begin
            ram_we = 1'b1;
          end else begin
            stall   = 1'b1;
            idx_d   = a[AW+1:2];
            lane_d  = a[1:0];
            be_d    = byte_enable;
            byte_d  = wd[7:0];
            state_d = memwrite ? STORE_MERGE : LOAD_RESP;
          end
        end
      end
      LOAD_RESP: begin
        ram_addr   = idx_q;
        resp_valid = 1'b1;
        rd         = be_q ? extract_byte(ram_rdata, lane_q, SIGN_EXT)
                          : ram_rdata;
        state_d    = IDLE;
      end
      STORE_MERGE: begin
        ram_addr  = idx_q;
        ram_we    = 1'b1;
        ram_wdata = merge_byte(ram_rdata, lane_q, byte_q);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset drops any pending merge and quiets all outputs
    if (reset) begin
      state_d    = IDLE;
      ram_we     = 1'b0;
      stall      = 1'b0;
      resp_valid = 1'b0;
      rd         = '0;
      misaligned = 1'b0;
    end
  end

endmodule
